// File: rtl/pipe_hazard_ctrl.sv
// Load-use hazard detection and operand forwarding for a DEPTH-stage post-decode scoreboard.
// Forwarding and stall are combinational from ID; scoreboard advances only when pipe_en=1.
module pipe_hazard_ctrl #(
    parameter int DATA_W   = 64,
    parameter int RADDR_W  = 4,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_en,
    input  logic                     id_valid,
    input  logic [RADDR_W-1:0]       id_rs0_addr,
    input  logic [RADDR_W-1:0]       id_rs1_addr,
    input  logic                     id_rs0_used,
    input  logic                     id_rs1_used,
    input  logic [DATA_W-1:0]        id_rs0_data,
    input  logic [DATA_W-1:0]        id_rs1_data,
    input  logic [RADDR_W-1:0]       id_rd_addr,
    input  logic                     id_wb_en,
    input  logic                     id_is_load,
    input  logic                     br_taken,
    input  logic [DEPTH*DATA_W-1:0]  res_data,
    input  logic                     cnt_clr,
    output logic [DATA_W-1:0]        fwd_rs0_data,
    output logic [DATA_W-1:0]        fwd_rs1_data,
    output logic                     stall,
    output logic                     id_kill,
    output logic [DEPTH-1:0]         sb_valid,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic [DEPTH-1:0]   sb_vld;
    logic [DEPTH-1:0]   sb_wb;
    logic [DEPTH-1:0]   sb_ld;
    logic [RADDR_W-1:0] sb_rd [DEPTH];
    logic               haz0;
    logic               haz1;

    // Walk oldest to youngest so the lowest-index match overrides any older one.
    always_comb begin
        fwd_rs0_data = id_rs0_data;
        fwd_rs1_data = id_rs1_data;
        haz0         = 1'b0;
        haz1         = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (sb_vld[k] && sb_wb[k] && id_rs0_used && (sb_rd[k] == id_rs0_addr)) begin
                fwd_rs0_data = res_data[k*DATA_W +: DATA_W];
                haz0         = sb_ld[k] && (k < LOAD_LAT);
            end
            if (sb_vld[k] && sb_wb[k] && id_rs1_used && (sb_rd[k] == id_rs1_addr)) begin
                fwd_rs1_data = res_data[k*DATA_W +: DATA_W];
                haz1         = sb_ld[k] && (k < LOAD_LAT);
            end
        end
    end

    assign stall    = id_valid && !br_taken && (haz0 || haz1);
    assign id_kill  = stall || br_taken || !id_valid;
    assign sb_valid = sb_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_vld    <= '0;
            sb_wb     <= '0;
            sb_ld     <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sb_rd[k] <= '0;
            end
        end else begin
            if (pipe_en) begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    sb_vld[k] <= sb_vld[k-1];
                    sb_wb[k]  <= sb_wb[k-1];
                    sb_ld[k]  <= sb_ld[k-1];
                    sb_rd[k]  <= sb_rd[k-1];
                end
                sb_vld[0] <= id_valid && !id_kill;
                sb_wb[0]  <= id_wb_en;
                sb_ld[0]  <= id_is_load;
                sb_rd[0]  <= id_rd_addr;
            end
            if (cnt_clr) begin
                stall_cnt <= '0;
            end else if (pipe_en && stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding priority, load-use stall, branch kill,
// pipe hold, counter saturation (second instance with CNT_W=4) and async reset.
module tb_pipe_hazard_ctrl;
    localparam int DATA_W = 64;
    localparam int RADDR_W = 4;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic reset, pipe_en, id_valid;
    logic [RADDR_W-1:0] id_rs0_addr, id_rs1_addr, id_rd_addr;
    logic id_rs0_used, id_rs1_used, id_wb_en, id_is_load, br_taken, cnt_clr;
    logic [DATA_W-1:0] id_rs0_data, id_rs1_data;
    logic [DEPTH*DATA_W-1:0] res_data;
    logic [DATA_W-1:0] fwd_rs0_data, fwd_rs1_data, fwd4_rs0, fwd4_rs1;
    logic stall, id_kill, stall4, kill4;
    logic [DEPTH-1:0] sb_valid, sb_valid4;
    logic [15:0] stall_cnt;
    logic [3:0] stall_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .DEPTH(DEPTH), .LOAD_LAT(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .pipe_en(pipe_en), .id_valid(id_valid),
        .id_rs0_addr(id_rs0_addr), .id_rs1_addr(id_rs1_addr),
        .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
        .id_rs0_data(id_rs0_data), .id_rs1_data(id_rs1_data),
        .id_rd_addr(id_rd_addr), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
        .br_taken(br_taken), .res_data(res_data), .cnt_clr(cnt_clr),
        .fwd_rs0_data(fwd_rs0_data), .fwd_rs1_data(fwd_rs1_data),
        .stall(stall), .id_kill(id_kill), .sb_valid(sb_valid), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .DEPTH(DEPTH), .LOAD_LAT(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .pipe_en(pipe_en), .id_valid(id_valid),
        .id_rs0_addr(id_rs0_addr), .id_rs1_addr(id_rs1_addr),
        .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
        .id_rs0_data(id_rs0_data), .id_rs1_data(id_rs1_data),
        .id_rd_addr(id_rd_addr), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
        .br_taken(br_taken), .res_data(res_data), .cnt_clr(cnt_clr),
        .fwd_rs0_data(fwd4_rs0), .fwd_rs1_data(fwd4_rs1),
        .stall(stall4), .id_kill(kill4), .sb_valid(sb_valid4), .stall_cnt(stall_cnt4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pipe_en = 1'b1; id_valid = 1'b0; br_taken = 1'b0; cnt_clr = 1'b0;
        id_rs0_addr = '0; id_rs1_addr = '0; id_rs0_used = 1'b0; id_rs1_used = 1'b0;
        id_rs0_data = 64'h1111; id_rs1_data = 64'h2222;
        id_rd_addr = '0; id_wb_en = 1'b0; id_is_load = 1'b0;
        res_data = {64'hC2, 64'hC1, 64'hC0};
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [RADDR_W-1:0] rd, input logic wb, input logic ld);
        id_valid = 1'b1; id_rd_addr = rd; id_wb_en = wb; id_is_load = ld;
        id_rs0_used = 1'b0; id_rs1_used = 1'b0;
        step();
        id_valid = 1'b0; id_wb_en = 1'b0; id_is_load = 1'b0;
    endtask

    task automatic read_srcs(input logic [RADDR_W-1:0] a0, input logic u0,
                             input logic [RADDR_W-1:0] a1, input logic u1);
        id_valid = 1'b1; id_wb_en = 1'b0; id_is_load = 1'b0; id_rd_addr = 4'd0;
        id_rs0_addr = a0; id_rs0_used = u0; id_rs1_addr = a1; id_rs1_used = u1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        id_rs0_data = 64'hDEAD; id_rs1_data = 64'hBEEF; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (id_kill !== 1'b1) begin errors++; $display("FAIL reset_kill: got %b want 1", id_kill); end
        checks++; if (sb_valid !== 3'b000) begin errors++; $display("FAIL reset_sb: got %b want 000", sb_valid); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        checks++; if (fwd_rs0_data !== 64'hDEAD || fwd_rs1_data !== 64'hBEEF) begin
            errors++; $display("FAIL reset_fwd: got %h %h want dead beef", fwd_rs0_data, fwd_rs1_data); end
    endtask

    task automatic test_forward();
        do_reset();
        issue(4'd3, 1'b1, 1'b0);
        res_data = {64'hC2, 64'hC1, 64'h55};
        id_rs1_data = 64'h77;
        read_srcs(4'd3, 1'b1, 4'd7, 1'b1);
        checks++; if (fwd_rs0_data !== 64'h55) begin errors++; $display("FAIL fwd_ex: got %h want 55", fwd_rs0_data); end
        checks++; if (fwd_rs1_data !== 64'h77) begin errors++; $display("FAIL fwd_nomatch: got %h want 77", fwd_rs1_data); end
        checks++; if (stall !== 1'b0 || id_kill !== 1'b0) begin
            errors++; $display("FAIL fwd_nostall: got stall=%b kill=%b want 0 0", stall, id_kill); end
        checks++; if (sb_valid !== 3'b001) begin errors++; $display("FAIL fwd_sb: got %b want 001", sb_valid); end
        // unused source must not forward
        read_srcs(4'd3, 1'b0, 4'd7, 1'b0);
        checks++; if (fwd_rs0_data !== 64'h1111) begin errors++; $display("FAIL fwd_unused: got %h want 1111", fwd_rs0_data); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(4'd2, 1'b1, 1'b1);
        res_data = {64'hB2, 64'hB1, 64'hB0};
        read_srcs(4'd9, 1'b1, 4'd2, 1'b1);
        checks++; if (stall !== 1'b1 || id_kill !== 1'b1) begin
            errors++; $display("FAIL lu_stall: got stall=%b kill=%b want 1 1", stall, id_kill); end
        step();
        checks++; if (stall !== 1'b0 || id_kill !== 1'b0) begin
            errors++; $display("FAIL lu_release: got stall=%b kill=%b want 0 0", stall, id_kill); end
        checks++; if (fwd_rs1_data !== 64'hB1) begin errors++; $display("FAIL lu_fwd: got %h want b1", fwd_rs1_data); end
        checks++; if (sb_valid !== 3'b010) begin errors++; $display("FAIL lu_sb: got %b want 010", sb_valid); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    endtask

    task automatic test_youngest();
        do_reset();
        issue(4'd5, 1'b1, 1'b0);
        issue(4'd9, 1'b1, 1'b0);
        issue(4'd5, 1'b1, 1'b0);
        res_data = {64'hB, 64'h9, 64'hA};
        read_srcs(4'd5, 1'b1, 4'd5, 1'b1);
        checks++; if (fwd_rs0_data !== 64'hA || fwd_rs1_data !== 64'hA) begin
            errors++; $display("FAIL young: got %h %h want a a", fwd_rs0_data, fwd_rs1_data); end
        issue(4'd6, 1'b0, 1'b0);
        res_data = {64'hE2, 64'hE1, 64'hE0};
        read_srcs(4'd9, 1'b1, 4'd6, 1'b1);
        checks++; if (fwd_rs0_data !== 64'hE2) begin errors++; $display("FAIL fwd_wb_stage: got %h want e2", fwd_rs0_data); end
        checks++; if (fwd_rs1_data !== 64'h2222) begin errors++; $display("FAIL fwd_no_wben: got %h want 2222", fwd_rs1_data); end
    endtask

    task automatic test_branch();
        do_reset();
        issue(4'd2, 1'b1, 1'b1);
        read_srcs(4'd2, 1'b1, 4'd0, 1'b0);
        br_taken = 1'b1; id_wb_en = 1'b1; id_rd_addr = 4'd4; #1;
        checks++; if (stall !== 1'b0 || id_kill !== 1'b1) begin
            errors++; $display("FAIL br_prio: got stall=%b kill=%b want 0 1", stall, id_kill); end
        step();
        br_taken = 1'b0;
        checks++; if (sb_valid !== 3'b010) begin errors++; $display("FAIL br_sb: got %b want 010", sb_valid); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL br_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_hold();
        do_reset();
        issue(4'd4, 1'b1, 1'b1);
        read_srcs(4'd4, 1'b1, 4'd0, 1'b0);
        pipe_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (stall !== 1'b1 || sb_valid !== 3'b001 || stall_cnt !== 16'd0) begin
                errors++; $display("FAIL hold_%0d: got stall=%b sb=%b cnt=%0d want 1 001 0", i, stall, sb_valid, stall_cnt); end
        end
        pipe_en = 1'b1;
        step();
        checks++; if (stall !== 1'b0 || stall_cnt !== 16'd1 || sb_valid !== 3'b010) begin
            errors++; $display("FAIL hold_resume: got stall=%b cnt=%0d sb=%b want 0 1 010", stall, stall_cnt, sb_valid); end
    endtask

    task automatic test_saturate();
        do_reset();
        issue(4'd2, 1'b1, 1'b1);
        // a load that reads and writes r2 stalls on every other cycle
        read_srcs(4'd2, 1'b1, 4'd0, 1'b0);
        id_wb_en = 1'b1; id_is_load = 1'b1; id_rd_addr = 4'd2; #1;
        for (int i = 0; i < 40; i++) step();
        checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16: got %0d want 20", stall_cnt); end
        checks++; if (stall_cnt4 !== 4'hF) begin errors++; $display("FAIL sat_cnt4: got %h want f", stall_cnt4); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b want 1", stall); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++; if (stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
            errors++; $display("FAIL clr_prio: got %0d %0d want 0 0", stall_cnt, stall_cnt4); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        issue(4'd2, 1'b1, 1'b0);
        issue(4'd2, 1'b1, 1'b1);
        read_srcs(4'd2, 1'b1, 4'd0, 1'b0);
        step();
        read_srcs(4'd2, 1'b1, 4'd0, 1'b0);
        issue(4'd2, 1'b1, 1'b1);
        read_srcs(4'd2, 1'b1, 4'd0, 1'b0);
        checks++; if (stall !== 1'b1 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL pre_rst: got stall=%b cnt=%0d want 1 1", stall, stall_cnt); end
        reset = 1'b1; #1;
        checks++; if (sb_valid !== 3'b000 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL async_rst: got sb=%b stall=%b cnt=%0d want 000 0 0", sb_valid, stall, stall_cnt); end
        step();
        reset = 1'b0; #1;
        checks++; if (stall !== 1'b0 || fwd_rs0_data !== 64'h1111) begin
            errors++; $display("FAIL post_rst: got stall=%b fwd=%h want 0 1111", stall, fwd_rs0_data); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_branch();
        test_hold();
        test_saturate();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
